// File: rtl/mlp_xor_ctrl.sv
// Sequencer and weight/bias register bank for the 2-3-1 XOR MLP datapath.
// Optional inference counter output enabled by defining MLP_XOR_CTRL_STATS_EN.
module mlp_xor_ctrl #(
    parameter int LATENCY    = 3,
    parameter int NUM_PARAMS = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_addr,
    input  logic signed [7:0]         cfg_data,
    output logic                      cfg_ready,
    output logic                      cfg_complete,
    output logic                      cfg_err,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_a,
    input  logic                      in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_result,
    output logic                      mlp_in1,
    output logic                      mlp_in2,
    output logic [8*NUM_PARAMS-1:0]   mlp_params,
    input  logic                      mlp_final_out
`ifdef MLP_XOR_CTRL_STATS_EN
    ,
    output logic [15:0]               inf_count
`endif
);

    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {CFG, IDLE, RUN, RESP} state_t;

    state_t                    state_q, state_d;
    logic [NUM_PARAMS-1:0]     mask_q, mask_d;
    logic [8*NUM_PARAMS-1:0]   params_q, params_d;
    logic                      err_q, err_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      in1_q, in1_d;
    logic                      in2_q, in2_d;
    logic                      ov_q, ov_d;
    logic                      res_q, res_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CFG;
            mask_q   <= '0;
            params_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            in1_q    <= 1'b0;
            in2_q    <= 1'b0;
            ov_q     <= 1'b0;
            res_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            params_q <= params_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            ov_q     <= ov_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        params_d  = params_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        ov_d      = ov_q;
        res_d     = res_q;
        cfg_ready = (state_q == CFG) || (state_q == IDLE);
        in_ready  = (state_q == IDLE);

        // Out-of-range writes complete the handshake but only raise the sticky error.
        if (cfg_ready && cfg_we) begin
            if (int'(cfg_addr) >= NUM_PARAMS) begin
                err_d = 1'b1;
            end else begin
                for (int n = 0; n < NUM_PARAMS; n++) begin
                    if (cfg_addr == 4'(n)) begin
                        params_d[8*n +: 8] = cfg_data;
                        mask_d[n]          = 1'b1;
                    end
                end
            end
        end

        case (state_q)
            CFG: begin
                if (&mask_d) state_d = IDLE;
            end
            IDLE: begin
                if (in_valid) begin
                    in1_d   = in_a;
                    in2_d   = in_b;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(LATENCY)) begin
                    res_d   = mlp_final_out;
                    ov_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = CFG;
        endcase
    end

`ifdef MLP_XOR_CTRL_STATS_EN
    logic [15:0] inf_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            inf_count_q <= '0;
        end else if (ov_q && out_ready && (inf_count_q != 16'hFFFF)) begin
            inf_count_q <= inf_count_q + 16'd1;
        end
    end

    assign inf_count = inf_count_q;
`endif

    assign cfg_complete = &mask_q;
    assign cfg_err      = err_q;
    assign out_valid    = ov_q;
    assign out_result   = res_q;
    assign mlp_in1      = in1_q;
    assign mlp_in2      = in2_q;
    assign mlp_params   = params_q;

endmodule

// File: tb/tb_mlp_xor_ctrl.sv
// Directed bench for mlp_xor_ctrl; a 3-stage XOR delay line stands in for the MLP.
module tb_mlp_xor_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_we;
    logic [3:0]   cfg_addr;
    logic [7:0]   cfg_data;
    logic         cfg_ready, cfg_complete, cfg_err;
    logic         in_valid, in_ready, in_a, in_b;
    logic         out_valid, out_ready, out_result;
    logic         mlp_in1, mlp_in2;
    logic [103:0] mlp_params;
    logic         mlp_final_out;
`ifdef MLP_XOR_CTRL_STATS_EN
    logic [15:0]  inf_count;
`endif

    int           total = 0;
    int           bad   = 0;
    int           n_inf = 0;
    logic [103:0] exp_params;
    logic [7:0]   vals [13];
    logic         p1, p2, p3;

    always #5 clk = ~clk;

    mlp_xor_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready),
        .cfg_complete (cfg_complete),
        .cfg_err      (cfg_err),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .mlp_in1      (mlp_in1),
        .mlp_in2      (mlp_in2),
        .mlp_params   (mlp_params),
        .mlp_final_out(mlp_final_out)
`ifdef MLP_XOR_CTRL_STATS_EN
        ,
        .inf_count    (inf_count)
`endif
    );

    // Stand-in for the MLP: result appears 3 edges after the inputs change.
    always @(posedge clk) begin
        if (reset) begin
            p1 <= 1'b0; p2 <= 1'b0; p3 <= 1'b0;
        end else begin
            p1 <= mlp_in1 ^ mlp_in2; p2 <= p1; p3 <= p2;
        end
    end
    assign mlp_final_out = p3;

    task automatic chk(input string tag, input logic [103:0] got, input logic [103:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic load_all();
        for (int n = 0; n < 13; n++) cfg_write(4'(n), vals[n]);
    endtask

    // Caller guarantees the DUT is in IDLE; hold>0 stalls the response and pokes cfg.
    task automatic do_infer(input logic a, input logic b, input int hold);
        int  n;
        logic r;
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            chk("run_in1", 104'(mlp_in1), 104'(a));
            chk("run_in2", 104'(mlp_in2), 104'(b));
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 104'(n), 104'(4));
        chk("result", 104'(out_result), 104'(a ^ b));
        r = out_result;
        for (int h = 0; h < hold; h++) begin
            cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'h55;
            @(posedge clk); #1;
            chk("hold_valid", 104'(out_valid), 104'(1));
            chk("hold_result", 104'(out_result), 104'(r));
            chk("hold_in_ready", 104'(in_ready), 104'(0));
            chk("hold_cfg_ready", 104'(cfg_ready), 104'(0));
            chk("hold_params", mlp_params, exp_params);
        end
        cfg_we = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("resp_drop", 104'(out_valid), 104'(0));
        chk("back_idle", 104'(in_ready), 104'(1));
        if (n_inf != 16'hFFFF) n_inf++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vals = '{8'd20, 8'd20, -8'sd10, -8'sd20, -8'sd20, 8'd30, 8'd0, 8'd0, 8'd0,
                 8'd20, 8'd20, 8'd0, -8'sd30};
        for (int n = 0; n < 13; n++) exp_params[8*n +: 8] = vals[n];
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_out_valid", 104'(out_valid), 104'(0));
        chk("rst_complete", 104'(cfg_complete), 104'(0));
        chk("rst_err", 104'(cfg_err), 104'(0));
        chk("rst_params", mlp_params, 104'(0));
        chk("rst_in_ready", 104'(in_ready), 104'(0));
        chk("rst_cfg_ready", 104'(cfg_ready), 104'(1));

        for (int n = 0; n < 12; n++) cfg_write(4'(n), vals[n]);
        chk("partial_complete", 104'(cfg_complete), 104'(0));
        chk("partial_in_ready", 104'(in_ready), 104'(0));
        cfg_write(4'd12, vals[12]);
        chk("full_complete", 104'(cfg_complete), 104'(1));
        chk("full_in_ready", 104'(in_ready), 104'(1));
        chk("full_params", mlp_params, exp_params);

        do_infer(1'b1, 1'b0, 5);
        do_infer(1'b0, 1'b0, 0);
        do_infer(1'b1, 1'b1, 0);
        do_infer(1'b0, 1'b1, 0);

        // Config write and request in the same IDLE cycle.
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 8'hF5;
        in_a = 1'b1; in_b = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        exp_params[23:16] = 8'hF5;
        chk("both_params", mlp_params, exp_params);
        chk("both_in1", 104'(mlp_in1), 104'(1));
        chk("both_running", 104'(in_ready), 104'(0));
        repeat (4) @(posedge clk);
        #1;
        chk("both_valid", 104'(out_valid), 104'(1));
        chk("both_result", 104'(out_result), 104'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_inf++;

        cfg_write(4'd13, 8'h7F);
        chk("bad_addr_err", 104'(cfg_err), 104'(1));
        chk("bad_addr_params", mlp_params, exp_params);
        repeat (10) @(posedge clk);
        #1;
        chk("err_sticky", 104'(cfg_err), 104'(1));
`ifdef MLP_XOR_CTRL_STATS_EN
        chk("count_pre_reset", 104'(inf_count), 104'(n_inf));
`endif

        // Reset while RUN has counted to 2.
        in_a = 1'b1; in_b = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_inf = 0;
        exp_params[23:16] = vals[2];
        chk("mid_rst_valid", 104'(out_valid), 104'(0));
        chk("mid_rst_complete", 104'(cfg_complete), 104'(0));
        chk("mid_rst_params", mlp_params, 104'(0));
        chk("mid_rst_err", 104'(cfg_err), 104'(0));
        chk("mid_rst_cfg_state", 104'(cfg_ready), 104'(1));
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_accept_in_ready", 104'(in_ready), 104'(0));
            chk("no_accept_valid", 104'(out_valid), 104'(0));
        end
        in_valid = 1'b0;
        load_all();
        chk("reload_in_ready", 104'(in_ready), 104'(1));

        do_infer(1'b0, 1'b1, 0);
        do_infer(1'b1, 1'b1, 0);
        do_infer(1'b1, 1'b0, 0);
`ifdef MLP_XOR_CTRL_STATS_EN
        chk("count_three", 104'(inf_count), 104'(3));
        force dut.inf_count_q = 16'hFFFF;
        #1 release dut.inf_count_q;
        n_inf = 16'hFFFF;
        do_infer(1'b0, 1'b0, 0);
        chk("count_saturate", 104'(inf_count), 104'(n_inf));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
